// File: rtl/mem_hexdump_tx_if.sv
// ---------------------------------------------------------------------------
// mem_hexdump_tx_if
//   Bundles the control, memory-read and byte-stream signals of the
//   mem_hexdump_tx block. The clock and reset are plain module ports.
//
//   master : the dump engine (drives busy/done, memory address/enable and
//            the tx byte; receives start, read data and tx_ready)
//   slave  : the surrounding system (memory, sink, controller)
//
//   Signals:
//     start    ctrl  one-cycle dump request
//     busy     ctrl  dump in progress
//     done     ctrl  one-cycle completion pulse
//     mem_re   mem   read enable
//     mem_ra   mem   row address    (AWA bits)
//     mem_rc   mem   column address (AWC bits)
//     mem_rd   mem   read data, one cycle after mem_re (WB bits)
//     tx_data  tx    ASCII byte
//     tx_valid tx    byte valid
//     tx_ready tx    sink ready
// ---------------------------------------------------------------------------
interface mem_hexdump_tx_if #(
  parameter int WA = 8,
  parameter int WC = 8,
  parameter int WB = 8
);
  localparam int AWA = (WA > 1) ? $clog2(WA) : 1;
  localparam int AWC = (WC > 1) ? $clog2(WC) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic           mem_re;
  logic [AWA-1:0] mem_ra;
  logic [AWC-1:0] mem_rc;
  logic [WB-1:0]  mem_rd;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;

  modport master (
    input  start, mem_rd, tx_ready,
    output busy, done, mem_re, mem_ra, mem_rc, tx_data, tx_valid
  );

  modport slave (
    output start, mem_rd, tx_ready,
    input  busy, done, mem_re, mem_ra, mem_rc, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_hexdump_tx.sv
// ---------------------------------------------------------------------------
// mem_hexdump_tx
//   Streams a WA x WC array of WB-bit words as ASCII hex text in the standard
//   hex memory-file line format: each word as ND lowercase hex digits (MSB
//   nibble first, leading zeros kept) followed by a space, each row ended by a
//   newline. Row is the major index, column the minor, both ascending.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mem_hexdump_tx_if.master (start/busy/done, synchronous-read
//            memory port, valid/ready byte stream)
//
//   Per word: READ (mem_re) -> LOAD (capture, first digit registered)
//   -> DIGIT x ND -> SEP; after the last column EOL emits the newline.
//   Byte-producing states advance only when the sink accepts the byte.
// ---------------------------------------------------------------------------
module mem_hexdump_tx #(
  parameter int WA = 8,
  parameter int WC = 8,
  parameter int WB = 8
) (
  input logic              clk,
  input logic              rst_n,
  mem_hexdump_tx_if.master bus
);
  localparam int ND  = (WB + 3) / 4;
  localparam int NW  = 4 * ND;
  localparam int AWA = (WA > 1) ? $clog2(WA) : 1;
  localparam int AWC = (WC > 1) ? $clog2(WC) : 1;
  localparam int DW  = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_DIGIT, S_SEP, S_EOL, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [AWA-1:0] row_q, row_d;
  logic [AWC-1:0] col_q, col_d;
  logic [DW-1:0]  dig_q, dig_d;
  logic [NW-1:0]  sh_q, sh_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;

  logic           accept;
  logic           last_col;
  logic           last_row;
  logic [NW-1:0]  word_ext;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 0x57 + 10 = 0x61 ('a')
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign accept   = tx_valid_q && bus.tx_ready;
  assign last_col = (col_q == AWC'(WC - 1));
  assign last_row = (row_q == AWA'(WA - 1));
  // Zero-extends a word whose width is not a multiple of 4.
  assign word_ext = NW'(bus.mem_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      dig_q      <= '0;
      sh_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other, regardless of statement order.
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dig_q      <= dig_d;
      sh_q       <= sh_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to "hold" before the case, so
    // no path leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    dig_d      = dig_q;
    sh_d       = sh_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        // Read data is valid this cycle; register the first digit directly
        // and keep the remaining nibbles in the shift register.
        tx_data_d  = hex_char(word_ext[NW-1 -: 4]);
        tx_valid_d = 1'b1;
        sh_d       = word_ext << 4;
        dig_d      = '0;
        state_d    = S_DIGIT;
      end
      S_DIGIT: begin
        if (accept) begin
          if (dig_q == DW'(ND - 1)) begin
            tx_data_d = 8'h20;
            state_d   = S_SEP;
          end else begin
            tx_data_d = hex_char(sh_q[NW-1 -: 4]);
            sh_d      = sh_q << 4;
            dig_d     = dig_q + 1'b1;
          end
        end
      end
      S_SEP: begin
        if (accept) begin
          if (last_col) begin
            tx_data_d = 8'h0A;
            state_d   = S_EOL;
          end else begin
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            col_d      = col_q + 1'b1;
            state_d    = S_READ;
          end
        end
      end
      S_EOL: begin
        if (accept) begin
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          col_d      = '0;
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy drops in the DONE cycle, together with the done pulse.
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.mem_re   = (state_q == S_READ);
  assign bus.mem_ra   = row_q;
  assign bus.mem_rc   = col_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_mem_hexdump_tx.sv
// ---------------------------------------------------------------------------
// tb_mem_hexdump_tx
//   Three instances: 8x8x8 (main scenarios), 2x3x10 and 1x1x4. Expected
//   byte streams are built from the array contents with plain arithmetic;
//   one forked monitor checks every accepted byte, every read address,
//   byte stability under backpressure and busy at done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_hexdump_tx;
  logic clk;
  logic rst_n;
  logic rnd_ready;

  mem_hexdump_tx_if #(.WA(8), .WC(8), .WB(8))  a_if ();
  mem_hexdump_tx_if #(.WA(2), .WC(3), .WB(10)) b_if ();
  mem_hexdump_tx_if #(.WA(1), .WC(1), .WB(4))  c_if ();

  mem_hexdump_tx #(.WA(8), .WC(8), .WB(8))  u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.master));
  mem_hexdump_tx #(.WA(2), .WC(3), .WB(10)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.master));
  mem_hexdump_tx #(.WA(1), .WC(1), .WB(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.master));

  logic [7:0] mem_a [8][8];
  logic [9:0] mem_b [2][3];
  logic [3:0] mem_c [1][1];

  // synchronous-read memories: data one cycle after mem_re
  always @(posedge clk) if (a_if.mem_re) a_if.mem_rd <= mem_a[a_if.mem_ra][a_if.mem_rc];
  always @(posedge clk) if (b_if.mem_re) b_if.mem_rd <= mem_b[b_if.mem_ra][b_if.mem_rc];
  always @(posedge clk) if (c_if.mem_re) c_if.mem_rd <= mem_c[0][0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sink ready for instance A, changed just after each rising edge
  initial begin
    a_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_if.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [3][$];
  logic [7:0] got_q [3][$];
  logic [7:0] ref_q [$];
  int         idx  [3];
  int         rcnt [3];
  int         dcnt [3];
  logic       hold_v [3];
  logic [7:0] hold_d [3];
  int         c_nz = 0;

  string l0, l7, b0, b1, c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected text for one word: nd hex digits MSB first, then a space
  task automatic push_word(input int id, input int val, input int nd);
    for (int d = nd - 1; d >= 0; d--) begin
      int nib;
      nib = (val >> (4 * d)) & 15;
      exp_q[id].push_back(8'(nib < 10 ? 48 + nib : 87 + nib));
    end
    exp_q[id].push_back(8'h20);
  endtask

  task automatic clr(input int id);
    got_q[id].delete();
    idx[id]    = 0;
    rcnt[id]   = 0;
    dcnt[id]   = 0;
    hold_v[id] = 1'b0;
  endtask

  task automatic mon(input int id, input logic v, input logic r, input logic [7:0] d,
                     input logic dn, input logic bz, input logic re,
                     input int ra, input int rc, input int wc);
    if (!rst_n) begin
      idx[id]    = 0;
      rcnt[id]   = 0;
      hold_v[id] = 1'b0;
      return;
    end
    if (hold_v[id])
      check($sformatf("hold%0d", id), 32'({v, d}), 32'({1'b1, hold_d[id]}));
    hold_v[id] = v && !r;
    hold_d[id] = d;
    if (v && r) begin
      if (idx[id] < exp_q[id].size())
        check($sformatf("byte%0d[%0d]", id, idx[id]), 32'(d), 32'(exp_q[id][idx[id]]));
      else
        check($sformatf("overrun%0d", id), 32'(idx[id]), 32'(exp_q[id].size() - 1));
      got_q[id].push_back(d);
      idx[id]++;
    end
    if (re) begin
      check($sformatf("ra%0d[%0d]", id, rcnt[id]), 32'(ra), 32'(rcnt[id] / wc));
      check($sformatf("rc%0d[%0d]", id, rcnt[id]), 32'(rc), 32'(rcnt[id] % wc));
      rcnt[id]++;
    end
    if (dn) begin
      dcnt[id]++;
      check($sformatf("busy_at_done%0d", id), 32'(bz), 32'd0);
    end
  endtask

  task automatic pulse(input int id);
    @(posedge clk);
    #1;
    case (id)
      0: a_if.start = 1'b1;
      1: b_if.start = 1'b1;
      default: c_if.start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    int d0;
    int n;
    d0 = dcnt[id];
    n  = 0;
    while (dcnt[id] == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (dcnt[id] == d0) check($sformatf("timeout%0d", id), 32'(dcnt[id] - d0), 32'd1);
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int id, input int cnt);
    int n;
    n = 0;
    while (got_q[id].size() < cnt && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("reach%0d_%0d", id, cnt), 32'(got_q[id].size() >= cnt), 32'd1);
  endtask

  // rebuild the 8x8 array from the text stream, as a hex memory-file loader would
  function automatic int reparse_bad();
    logic [7:0] p [8][8];
    logic [7:0] acc;
    logic [7:0] b;
    int r, c, nbad;
    foreach (p[i, j]) p[i][j] = 'x;
    acc = '0; r = 0; c = 0; nbad = 0;
    for (int k = 0; k < got_q[0].size(); k++) begin
      b = got_q[0][k];
      if (b >= 8'h30 && b <= 8'h39) acc = {acc[3:0], 4'(b - 8'h30)};
      else if (b >= 8'h61 && b <= 8'h66) acc = {acc[3:0], 4'(b - 8'h57)};
      else if (b == 8'h20) begin
        if (r < 8 && c < 8) p[r][c] = acc;
        c++;
        acc = '0;
      end else if (b == 8'h0A) begin
        r++;
        c = 0;
      end
    end
    foreach (p[i, j]) if (p[i][j] !== mem_a[i][j]) nbad++;
    return nbad;
  endfunction

  initial begin
    int n;
    int diffs;

    l0 = "00 01 02 03 04 05 06 07 \n";
    l7 = "70 71 72 73 74 75 76 77 \n";
    b0 = "3ff ";
    b1 = "000 000 005 \n";
    c0 = "a \n";

    foreach (mem_a[a, c]) mem_a[a][c] = 8'(a * 16 + c);
    foreach (mem_b[a, c]) mem_b[a][c] = 10'h000;
    mem_b[0][0] = 10'h3FF;
    mem_b[1][2] = 10'h005;
    mem_c[0][0] = 4'hA;

    for (int id = 0; id < 3; id++) begin
      exp_q[id].delete();
      clr(id);
    end
    for (int a = 0; a < 8; a++) begin
      for (int c = 0; c < 8; c++) push_word(0, int'(mem_a[a][c]), 2);
      exp_q[0].push_back(8'h0A);
    end
    for (int a = 0; a < 2; a++) begin
      for (int c = 0; c < 3; c++) push_word(1, int'(mem_b[a][c]), 3);
      exp_q[1].push_back(8'h0A);
    end
    push_word(2, int'(mem_c[0][0]), 1);
    exp_q[2].push_back(8'h0A);

    rnd_ready     = 1'b0;
    a_if.start    = 1'b0;
    b_if.start    = 1'b0;
    c_if.start    = 1'b0;
    b_if.tx_ready = 1'b1;
    c_if.tx_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon(0, a_if.tx_valid, a_if.tx_ready, a_if.tx_data, a_if.done, a_if.busy, a_if.mem_re,
            int'(a_if.mem_ra), int'(a_if.mem_rc), 8);
        mon(1, b_if.tx_valid, b_if.tx_ready, b_if.tx_data, b_if.done, b_if.busy, b_if.mem_re,
            int'(b_if.mem_ra), int'(b_if.mem_rc), 3);
        mon(2, c_if.tx_valid, c_if.tx_ready, c_if.tx_data, c_if.done, c_if.busy, c_if.mem_re,
            int'(c_if.mem_ra), int'(c_if.mem_rc), 1);
        if (c_if.mem_ra != 1'b0 || c_if.mem_rc != 1'b0) c_nz++;
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(a_if.busy),     32'd0);
    check("rst_done",   32'(a_if.done),     32'd0);
    check("rst_re",     32'(a_if.mem_re),   32'd0);
    check("rst_ra",     32'(a_if.mem_ra),   32'd0);
    check("rst_rc",     32'(a_if.mem_rc),   32'd0);
    check("rst_valid",  32'(a_if.tx_valid), 32'd0);
    check("rst_data",   32'(a_if.tx_data),  32'd0);
    rst_n = 1'b1;

    // S1: default dump, sink always ready, with latency
    clr(0);
    @(posedge clk);
    #1 a_if.start = 1'b1;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    check("c1_busy",  32'(a_if.busy),     32'd1);
    check("c1_re",    32'(a_if.mem_re),   32'd1);
    check("c1_addr",  32'({a_if.mem_ra, a_if.mem_rc}), 32'd0);
    check("c1_valid", 32'(a_if.tx_valid), 32'd0);
    @(posedge clk);
    #1;
    check("c2_re",    32'(a_if.mem_re),   32'd0);
    check("c2_valid", 32'(a_if.tx_valid), 32'd0);
    @(posedge clk);
    #1;
    check("c3_valid", 32'(a_if.tx_valid), 32'd1);
    check("c3_data",  32'(a_if.tx_data),  32'h30);
    wait_done(0, 2000);
    check("s1_bytes", 32'(got_q[0].size()), 32'd200);
    check("s1_done",  32'(dcnt[0]), 32'd1);
    check("s1_reads", 32'(rcnt[0]), 32'd64);
    check("s1_busy",  32'(a_if.busy), 32'd0);
    for (int i = 0; i < 25; i++) check($sformatf("line0[%0d]", i), 32'(got_q[0][i]), 32'(l0[i]));
    for (int i = 0; i < 25; i++) check($sformatf("line7[%0d]", i), 32'(got_q[0][175 + i]), 32'(l7[i]));
    check("reparse", 32'(reparse_bad()), 32'd0);
    ref_q = got_q[0];

    // S2: same dump with random backpressure
    clr(0);
    rnd_ready = 1'b1;
    pulse(0);
    wait_done(0, 4000);
    rnd_ready = 1'b0;
    diffs = 0;
    for (int i = 0; i < got_q[0].size() && i < ref_q.size(); i++)
      if (got_q[0][i] !== ref_q[i]) diffs++;
    check("s2_bytes", 32'(got_q[0].size()), 32'd200);
    check("s2_same",  32'(diffs), 32'd0);
    check("s2_reads", 32'(rcnt[0]), 32'd64);
    check("s2_done",  32'(dcnt[0]), 32'd1);

    // S3: asynchronous reset after the 37th accepted byte, then a fresh dump
    clr(0);
    pulse(0);
    wait_bytes(0, 37);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_busy",  32'(a_if.busy),     32'd0);
    check("ar_done",  32'(a_if.done),     32'd0);
    check("ar_re",    32'(a_if.mem_re),   32'd0);
    check("ar_ra",    32'(a_if.mem_ra),   32'd0);
    check("ar_rc",    32'(a_if.mem_rc),   32'd0);
    check("ar_valid", 32'(a_if.tx_valid), 32'd0);
    check("ar_data",  32'(a_if.tx_data),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ar_idle", 32'({a_if.busy, a_if.tx_valid}), 32'd0);
    clr(0);
    pulse(0);
    wait_done(0, 2000);
    check("s3_bytes", 32'(got_q[0].size()), 32'd200);
    check("s3_head",  32'({got_q[0][0], got_q[0][1], got_q[0][2]}), 32'h303020);
    check("s3_done",  32'(dcnt[0]), 32'd1);

    // S4: start while busy and in the done cycle are both ignored
    clr(0);
    pulse(0);
    wait_bytes(0, 10);
    pulse(0);
    n = 0;
    while (!a_if.done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("s4_done_seen", 32'(a_if.done), 32'd1);
    a_if.start = 1'b1;
    @(posedge clk);
    #1 a_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("s4_busy",  32'(a_if.busy), 32'd0);
    check("s4_bytes", 32'(got_q[0].size()), 32'd200);
    check("s4_done",  32'(dcnt[0]), 32'd1);
    check("s4_reads", 32'(rcnt[0]), 32'd64);

    // 2x3 array of 10-bit words: three digits per word
    clr(1);
    pulse(1);
    wait_done(1, 500);
    check("b_bytes", 32'(got_q[1].size()), 32'd26);
    check("b_reads", 32'(rcnt[1]), 32'd6);
    check("b_done",  32'(dcnt[1]), 32'd1);
    for (int i = 0; i < 4; i++)  check($sformatf("bline0[%0d]", i), 32'(got_q[1][i]), 32'(b0[i]));
    for (int i = 0; i < 13; i++) check($sformatf("bline1[%0d]", i), 32'(got_q[1][13 + i]), 32'(b1[i]));

    // 1x1 array of 4-bit words
    clr(2);
    pulse(2);
    wait_done(2, 100);
    check("c_bytes", 32'(got_q[2].size()), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("cline[%0d]", i), 32'(got_q[2][i]), 32'(c0[i]));
    check("c_done",   32'(dcnt[2]), 32'd1);
    check("c_reads",  32'(rcnt[2]), 32'd1);
    check("c_ctr_0",  32'(c_nz), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_hexdump_tx.md
Name: mem_hexdump_tx

Overview:
- Streams the contents of a WA x WC array of WB-bit words out as an ASCII hex text stream, in the same line format that $readmemh consumes: one text line per row, each word as hex digits followed by a space, each row terminated by a newline.
- Acts as the writer side of the memory-file path; it is the synthesizable counterpart of the $writememh/$fwrite dump used by our unpacked-array readmem tests.
- Sits between a synchronous-read memory port and a byte-wide valid/ready sink such as a UART TX or a debug FIFO.

Parameters:
- WA, 8, number of rows (first unpacked dimension).
- WC, 8, number of columns (second unpacked dimension).
- WB, 8, word width in bits. ND = ceil(WB/4) hex digits per word (derived localparam).
- Address widths are derived: AWA = max(1, $clog2(WA)), AWC = max(1, $clog2(WC)).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final newline byte is accepted.
- mem_re  output  1  memory read enable.
- mem_ra  output  AWA  row address.
- mem_rc  output  AWC  column address.
- mem_rd  input  WB  read data, valid exactly one cycle after mem_re.
- tx_data  output  8  ASCII byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready.

Behaviour:
- Reset (asynchronous assertion, synchronous release): state=IDLE; busy=0, done=0, mem_re=0, mem_ra=0, mem_rc=0, tx_valid=0, tx_data=0. Row/column/digit counters are cleared. A reset mid-dump abandons the dump, and no partial stream resumes afterwards.
- States and transitions:
  - IDLE: on start, go to READ.
  - READ: mem_re=1 for one cycle at (row, col), then go to LOAD.
  - LOAD: capture mem_rd into the shift register, then go to DIGIT.
  - DIGIT: emit ND digits, then go to SEP.
  - SEP: emit a space. If col < WC-1, col++ and go to READ. Otherwise go to EOL.
  - EOL: emit a newline. If row < WA-1, row++, col=0 and go to READ. Otherwise go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Latency: start accepted in cycle 0; mem_re in cycle 1; data captured in cycle 2; first tx_valid in cycle 3.
- Digit encoding:
  - Digits are emitted MSB nibble first, as lowercase ASCII: 0-9 -> 0x30-0x39, 10-15 -> 0x61-0x66.
  - When WB is not a multiple of 4, the top nibble is zero-extended.
  - Leading zeros are always emitted, so every word is exactly ND characters.
- Byte framing: separator is 0x20, end of line is 0x0A. Every row ends with "<space><newline>", including a trailing space after the last word.
- Total bytes per dump: WA*(WC*(ND+1)+1).
- Handshake:
  - tx_data and tx_valid are registered outputs.
  - Once tx_valid=1, both tx_valid and tx_data hold stable until tx_valid && tx_ready.
  - An FSM step that produces a byte advances only on acceptance.
  - With tx_ready held high, one byte is emitted per cycle during DIGIT/SEP/EOL. READ and LOAD add 2 bubble cycles per word.
- Reads:
  - mem_ra and mem_rc hold their values from READ through LOAD.
  - mem_re is never asserted outside READ.
  - Row index is the major index and column the minor, both ascending from 0: the same order in which $readmemh fills [a][c].
- Concurrent and boundary events:
  - start while busy is ignored and does not restart the dump.
  - start in the same cycle as done is ignored; it must be reasserted in IDLE.
  - tx_ready may be high while tx_valid=0; this has no effect.
  - WA=1 and/or WC=1 are legal; the counters must not overflow AWA/AWC when WA or WC is a power of 2.

Test Plan:
- Default 8x8x8, mem[a][c]={a[3:0],c[3:0]}, tx_ready=1, pulse start:
  - exactly 200 bytes out.
  - line 0 is "00 01 02 03 04 05 06 07 \n"; line 7 is "70 71 72 73 74 75 76 77 \n".
  - exactly one done pulse, busy falls with it.
  - the stream, written to a file, is loaded by $readmemh into a logic [7:0] [7:0][7:0] array and compares === to the source.
- Same stimulus with random tx_ready (50%):
  - byte stream identical to the previous scenario.
  - tx_data/tx_valid never change while tx_valid && !tx_ready.
  - mem_re asserted exactly 64 times.
- WA=2, WC=3, WB=10, mem[0][0]=0x3FF, mem[1][2]=0x005, others 0x000:
  - ND=3, total 2*(3*4+1)=26 bytes.
  - line 0 starts "3ff "; line 1 is "000 000 005 \n".
- Assert rst_n=0 asynchronously after the 37th accepted byte:
  - all outputs 0 in the same cycle.
  - after release and a new start, the stream begins again at "00 " and is complete at 200 bytes.
- Pulse start again at byte 10 and in the done cycle:
  - both ignored; total still 200 bytes, one done pulse.
- WA=1, WC=1, WB=4, mem=0xA:
  - output "a \n" (0x61 0x20 0x0A), then done.
  - counters remain 0.
